// File: rtl/writeback_queue_pkg.sv
// Datapath widths and types shared by the writeback queue,
// its lookup sub-module and its bus interface.
package datapath_defs;

    localparam int REGISTER_SIZE = 31;
    localparam int DATA_WIDTH    = REGISTER_SIZE + 1;
    localparam int ADDRESS_SIZE  = $clog2(REGISTER_SIZE + 1);

    typedef logic [DATA_WIDTH-1:0]   word_t;
    typedef logic [ADDRESS_SIZE-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REGISTER = '0;

    typedef struct packed {
        reg_addr_t address;
        word_t     data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_queue_if.sv
// Result handshake from writeback plus the register file
// write port driven by the queue.
interface writeback_queue_if;
    import datapath_defs::*;

    logic      in_valid;
    logic      in_ready;
    reg_addr_t in_address;
    word_t     in_data;
    logic      port_grant;
    logic      write_enable;
    reg_addr_t write_address;
    word_t     write_data;

    modport master (
        output in_valid, in_address, in_data, port_grant,
        input  in_ready, write_enable, write_address, write_data
    );

    modport slave (
        input  in_valid, in_address, in_data, port_grant,
        output in_ready, write_enable, write_address, write_data
    );

endinterface

// File: rtl/writeback_queue_pending_match.sv
// Youngest-match search over the live queue entries for
// one decode lookup address.
module pending_match
    import datapath_defs::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  reg_addr_t                lookup_address,
    input  wb_entry_t [DEPTH-1:0]    entries,
    input  logic      [PTR_W-1:0]    head,
    input  logic      [CNT_W-1:0]    count,
    output logic                     hit,
    output word_t                    data
);

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (CNT_W'(i) < count &&
                entries[idx].address == lookup_address &&
                lookup_address != ZERO_REGISTER) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Program-order buffer between writeback and the register
// file write port, with two decode forwarding lookups.
module writeback_queue
    import datapath_defs::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                system_clock,
    input  logic                system_reset_n,
    writeback_queue_if.slave    bus,
    input  reg_addr_t           lookup_address_1,
    input  reg_addr_t           lookup_address_2,
    output logic                lookup_hit_1,
    output logic                lookup_hit_2,
    output word_t               lookup_data_1,
    output word_t               lookup_data_2,
    output logic [CNT_W-1:0]    occupancy
);

    wb_entry_t [DEPTH-1:0] entries;
    logic      [PTR_W-1:0] head;
    logic      [PTR_W-1:0] tail;
    logic      [CNT_W-1:0] count;
    logic                  push;
    logic                  pop;

    assign bus.write_enable  = bus.port_grant && count != '0;
    assign pop               = bus.write_enable;
    assign bus.in_ready      = (count < CNT_W'(DEPTH)) || pop;
    // r0 results complete the handshake but are never stored.
    assign push              = bus.in_valid && bus.in_ready &&
                               bus.in_address != ZERO_REGISTER;
    assign bus.write_address = entries[head].address;
    assign bus.write_data    = entries[head].data;
    assign occupancy         = count;

    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            entries <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                entries[tail] <= '{address: bus.in_address,
                                   data:    bus.in_data};
                tail          <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    pending_match #(.DEPTH(DEPTH)) u_match_1 (
        .lookup_address (lookup_address_1),
        .entries        (entries),
        .head           (head),
        .count          (count),
        .hit            (lookup_hit_1),
        .data           (lookup_data_1)
    );

    pending_match #(.DEPTH(DEPTH)) u_match_2 (
        .lookup_address (lookup_address_2),
        .entries        (entries),
        .head           (head),
        .count          (count),
        .hit            (lookup_hit_2),
        .data           (lookup_data_2)
    );

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: directed scenarios
// followed by randomized traffic against a queue model.
module tb_writeback_queue;
    import datapath_defs::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    writeback_queue_if bus();
    reg_addr_t   la1, la2;
    logic        hit1, hit2;
    word_t       ld1, ld2;
    logic [2:0]  occ;

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .system_clock     (clk),
        .system_reset_n   (rst_n),
        .bus              (bus),
        .lookup_address_1 (la1),
        .lookup_address_2 (la2),
        .lookup_hit_1     (hit1),
        .lookup_hit_2     (hit2),
        .lookup_data_1    (ld1),
        .lookup_data_2    (ld2),
        .occupancy        (occ)
    );

    int checks = 0;
    int errors = 0;
    wb_entry_t model[$];
    bit acc_flag = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Youngest pending value for an address: last match in the queue.
    function automatic void ref_lookup(input reg_addr_t a,
                                       output bit h, output word_t d);
        h = 1'b0;
        d = '0;
        if (a != 0)
            foreach (model[i])
                if (model[i].address == a) begin
                    h = 1'b1;
                    d = model[i].data;
                end
    endfunction

    // Monitor: model holds the state the DUT should be in right now.
    always @(negedge clk) begin
        bit        exp_we, exp_rdy, h;
        word_t     d;
        wb_entry_t e;
        if (!rst_n) model.delete();
        exp_we  = rst_n && bus.port_grant && model.size() != 0;
        exp_rdy = (model.size() < DEPTH) || exp_we;
        chk("write_enable", bus.write_enable, exp_we);
        chk("in_ready", bus.in_ready, exp_rdy);
        chk("occupancy", occ, model.size());
        ref_lookup(la1, h, d);
        chk("lookup_hit_1", hit1, h);
        if (h) chk("lookup_data_1", ld1, d);
        ref_lookup(la2, h, d);
        chk("lookup_hit_2", hit2, h);
        if (h) chk("lookup_data_2", ld2, d);
        if (bus.write_enable) begin
            if (model.size() == 0) begin
                chk("write_on_empty", bus.write_enable, 1'b0);
            end else begin
                e = model.pop_front();
                chk("write_address", bus.write_address, e.address);
                chk("write_data", bus.write_data, e.data);
            end
        end
        acc_flag = rst_n && bus.in_valid && exp_rdy;
        if (acc_flag && bus.in_address != 0)
            model.push_back('{address: bus.in_address, data: bus.in_data});
    end

    task automatic cyc(input bit v, input reg_addr_t a, input word_t d,
                       input bit g);
        @(posedge clk);
        #1;
        bus.in_valid   = v;
        bus.in_address = a;
        bus.in_data    = d;
        bus.port_grant = g;
    endtask

    task automatic idle(input bit g, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, g);
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_address = '0;
        bus.in_data    = '0;
        bus.port_grant = 1'b0;
        la1 = '0;
        la2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_we", bus.write_enable, 1'b0);
        chk("reset_ready", bus.in_ready, 1'b1);
        chk("reset_occ", occ, 0);
        chk("reset_hit1", hit1, 1'b0);
        rst_n = 1'b1;

        // Single write, granted immediately.
        cyc(1'b1, 5'd5, 32'h0000_00AA, 1'b1);
        idle(1'b1, 3);

        // Fill with the port blocked, then drain in order.
        for (int i = 1; i <= 4; i++)
            cyc(1'b1, reg_addr_t'(i), word_t'(32'h100 + i), 1'b0);
        idle(1'b0, 2);
        idle(1'b1, 5);

        // Full queue accepting alongside a pop.
        for (int i = 1; i <= 4; i++)
            cyc(1'b1, reg_addr_t'(i + 8), word_t'(32'h200 + i), 1'b0);
        cyc(1'b1, 5'd7, 32'h0000_0777, 1'b1);
        idle(1'b0, 2);
        idle(1'b1, 5);

        // Forwarding picks the youngest of two writes to r3.
        la1 = 5'd3;
        la2 = 5'd0;
        cyc(1'b1, 5'd3, 32'h11, 1'b0);
        cyc(1'b1, 5'd3, 32'h22, 1'b0);
        idle(1'b0, 2);
        idle(1'b1, 3);

        // Writes to r0 are swallowed.
        cyc(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1);
        idle(1'b1, 3);

        // Asynchronous reset with writes pending.
        la1 = 5'd12;
        la2 = 5'd13;
        cyc(1'b1, 5'd12, 32'hC, 1'b0);
        cyc(1'b1, 5'd13, 32'hD, 1'b0);
        cyc(1'b1, 5'd14, 32'hE, 1'b0);
        cyc(1'b0, '0, '0, 1'b1);
        #1;
        chk("pre_reset_we", bus.write_enable, 1'b1);
        chk("pre_reset_hit1", hit1, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_we", bus.write_enable, 1'b0);
        chk("async_occ", occ, 0);
        chk("async_hit1", hit1, 1'b0);
        chk("async_hit2", hit2, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1'b1, 4);

        // Randomized traffic; a stalled offer is held stable.
        for (int n = 0; n < 800; n++) begin
            @(posedge clk);
            #1;
            if (!(bus.in_valid && !acc_flag)) begin
                bus.in_valid   = ($urandom % 3) != 0;
                bus.in_address = reg_addr_t'($urandom_range(0, 7));
                bus.in_data    = $urandom;
            end
            bus.port_grant = (n % 64 < 20) ? (($urandom % 4) == 0)
                                           : (($urandom % 4) != 0);
            la1 = reg_addr_t'($urandom_range(0, 7));
            la2 = reg_addr_t'($urandom_range(0, 7));
        end
        idle(1'b1, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
# writeback_queue

Buffers completed results from the pipeline's writeback stage and drives the single write port of `general_purpose_register`, the producer end of that block's write interface. Accepts results with a valid/ready handshake, holds up to DEPTH pending writes in program order, and drains one per cycle when the register file write port is granted. Two lookup ports let decode forward pending results that the register file does not yet hold.

## Interface
- `REGISTER_SIZE`, 31, MSB index of data word (data width = REGISTER_SIZE+1)
- `ADDRESS_SIZE`, $clog2(REGISTER_SIZE+1), register address width
- `DEPTH`, 4, queue entries (power of two, ≥2)

- `system_clock` in 1: single clock, all state on rising edge
- `system_reset_n` in 1: asynchronous, active-low reset
- `in_valid` in 1: result offered
- `in_ready` out 1: queue accepts this cycle
- `in_address` in ADDRESS_SIZE: destination register
- `in_data` in REGISTER_SIZE+1: result value
- `port_grant` in 1: register file write port available this cycle
- `write_enable` out 1: to register file
- `write_address` out ADDRESS_SIZE: to register file
- `write_data` out REGISTER_SIZE+1: to register file
- `lookup_address_1`, `lookup_address_2` in ADDRESS_SIZE: decode operand addresses
- `lookup_hit_1`, `lookup_hit_2` out 1: pending write exists for address
- `lookup_data_1`, `lookup_data_2` out REGISTER_SIZE+1: youngest pending value
- `occupancy` out $clog2(DEPTH+1): entries held

## Operation
- Circular buffer: head/tail pointers (log2 DEPTH bits, wrap naturally) plus count register.
- Enqueue: `in_valid && in_ready` at rising edge writes entry at tail, tail+1.
- Address 0 results: handshake completes, entry not stored, count unchanged.
- Dequeue: `write_enable = port_grant && count != 0`; write_address/data = head entry (combinational from storage). Edge with write_enable high pops head.
- `in_ready = (count < DEPTH) || write_enable` — full queue accepts when a pop occurs same edge.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Ordering: strict FIFO; two writes to the same register reach the register file in arrival order.
- Lookup: compare address against all valid entries; hit = any match and address ≠ 0; data = youngest matching entry (nearest tail). Entry at head being written this cycle still hits. Incoming `in_data` is not forwarded (no combinational in→lookup path).
- `write_enable` low whenever `port_grant` low, regardless of count.

## Timing
- Reset (async assert, sync-free release): count=0, head=tail=0; outputs: write_enable=0, in_ready=1, lookup_hit_*=0, occupancy=0. write_address/write_data/lookup_data don't-care but must not be X-propagating into write_enable.
- Reset mid-operation: all pending entries discarded, no register file write issued after assertion.
- Latency: entry accepted at edge N is visible on write port and lookup in cycle N+1; written into register file at edge N+1 earliest (if queue was empty and port granted).
- Throughput: one enqueue and one dequeue per cycle sustained.
- Full with port_grant low: in_ready=0, state held; producer must keep in_valid/address/data stable.
- occupancy is the registered count.

## Structure
- Shared package (`datapath_defs`): data width, register address width, zero-register constant.
- One natural sub-module: `pending_match` — combinational youngest-match search across entries for one lookup address, instantiated twice.
- Storage: plain register array; no RAM macro.

## Test plan
- Reset, port_grant=1, enqueue (r5, 0x0000_00AA) → write_enable=1, write_address=5, write_data=0xAA next cycle; occupancy 1 then 0.
- port_grant=0, enqueue 4 entries r1..r4 → in_ready=0 after fourth, occupancy=4; raise port_grant → writes r1,r2,r3,r4 in order on 4 consecutive cycles.
- Full queue, port_grant=1, in_valid=1 with r7 → in_ready=1, r7 accepted same edge as head pop, occupancy stays 4.
- port_grant=0, enqueue r3=0x11 then r3=0x22, lookup_address_1=3 → lookup_hit_1=1, lookup_data_1=0x22; lookup_address_2=0 → lookup_hit_2=0.
- Enqueue r0=0xFFFF_FFFF → in_ready=1, occupancy stays 0, no write_enable.
- Three entries pending, assert system_reset_n=0 asynchronously mid-cycle → write_enable, occupancy, lookup_hit_* drop immediately; after release no pending write appears.
